// File: rtl/mux_scan_sequencer_pkg.sv
// Shared definitions for the mux_scan_sequencer block.
//   state_t     : sequencer states (IDLE, MANUAL, SCAN)
//   sel_width() : select-register width, clog2(n) with a floor of 1
//   params_ok() : legal-range check used at elaboration time
package mux_scan_pkg;

  localparam int N_MIN     = 2;
  localparam int N_MAX     = 16;
  localparam int W_MIN     = 1;
  localparam int W_MAX     = 32;
  localparam int DWELL_MIN = 1;
  localparam int DWELL_MAX = 256;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } state_t;

  // A two-channel mux still needs one select bit, so clamp at 1.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic bit params_ok(input int n, input int w, input int dwell);
    return (n >= N_MIN) && (n <= N_MAX) &&
           (w >= W_MIN) && (w <= W_MAX) &&
           (dwell >= DWELL_MIN) && (dwell <= DWELL_MAX);
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// Channel/select bus of the mux_scan_sequencer.
//   master : source side, drives I, S, LOAD, MODE and observes the results
//   slave  : sequencer side, drives O, SEL, O_valid, WRAP, S_err
// Signals:
//   I      N*W packed channel data, channel k at I[k*W +: W]
//   S      channel index for a manual load
//   LOAD   latch S into the select register (manual mode only)
//   MODE   0 = manual, 1 = scan
//   O      registered data of the selected channel
//   SEL    current select register
//   O_valid O holds a sampled channel value
//   WRAP   one-cycle pulse when the scan wraps from channel N-1 to 0
//   S_err  one-cycle pulse when a manual load presented S >= N
interface mux_scan_sequencer_if
  import mux_scan_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
);

  localparam int SW = sel_width(N);

  logic [N*W-1:0] I;
  logic [SW-1:0]  S;
  logic           LOAD;
  logic           MODE;
  logic [W-1:0]   O;
  logic [SW-1:0]  SEL;
  logic           O_valid;
  logic           WRAP;
  logic           S_err;

  modport master (
    output I, S, LOAD, MODE,
    input  O, SEL, O_valid, WRAP, S_err
  );

  modport slave (
    input  I, S, LOAD, MODE,
    output O, SEL, O_valid, WRAP, S_err
  );

endinterface

// File: rtl/mux_scan_sequencer_dwell_counter.sv
// Dwell counter for scan mode: counts 0..DWELL-1 while enabled and wraps.
// Ports:
//   CLK    clock, rising edge
//   RESET  synchronous active-high reset, clears the count
//   en     advance the count this cycle
//   clr    synchronous clear (held while the sequencer is not scanning)
//   tc     terminal count, high while the count equals DWELL-1
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic en,
  input  logic clr,
  output logic tc
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0] count;

  // With DWELL=1 the count is pinned at 0, so tc is permanently high and the
  // scan advances every cycle.
  assign tc = (count == CW'(DWELL - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order blocks are evaluated in.
  always_ff @(posedge CLK) begin
    if (RESET || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tc ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/mux_scan_sequencer.sv
// Registered N-channel, W-bit selector with manual load and round-robin scan.
// Ports:
//   CLK    clock, rising edge
//   RESET  synchronous active-high reset (returns to IDLE, all outputs 0)
//   bus    mux_scan_sequencer_if.slave: I, S, LOAD, MODE in;
//          O, SEL, O_valid, WRAP, S_err out (all registered)
// Parameters: N channels (2..16), W bits per channel (1..32),
//             DWELL cycles per channel when scanning (1..256).
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 8,
  parameter int DWELL = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  mux_scan_sequencer_if.slave     bus
);

  localparam int SW = sel_width(N);

  if (!params_ok(N, W, DWELL)) begin : g_param_check
    $error("mux_scan_sequencer: parameter out of range (N=%0d W=%0d DWELL=%0d)",
           N, W, DWELL);
  end

  state_t        state;
  logic [W-1:0]  o_q;
  logic [SW-1:0] sel_q;
  logic          valid_q;
  logic          wrap_q;
  logic          err_q;

  logic          scanning;
  logic          tc;
  logic          sel_at_last;
  logic          bad_sel;
  logic [SW-1:0] sel_step;
  logic [W-1:0]  sel_data;

  assign scanning = (state == SCAN);

  // The counter is held at zero outside SCAN, so entering SCAN always starts
  // a fresh dwell on whatever channel SEL currently points at.
  dwell_counter #(
    .DWELL (DWELL)
  ) u_dwell (
    .CLK   (CLK),
    .RESET (RESET),
    .en    (scanning),
    .clr   (!scanning),
    .tc    (tc)
  );

  assign sel_at_last = (sel_q == SW'(N - 1));
  assign sel_step    = sel_at_last ? '0 : sel_q + 1'b1;

  // One extra bit so that S >= N is expressible when N is a power of two
  // (in which case the comparison is simply never true).
  assign bad_sel = ({1'b0, bus.S} >= (SW + 1)'(N));

  // Plain indexed mux over the packed channel bus. Comparing against each
  // legal index keeps the select from ever addressing past channel N-1.
  // NOTE: sel_data gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel_q == SW'(k)) begin
        sel_data = bus.I[k*W +: W];
      end
    end
  end

  // Single FSM block; every decision is taken on the pre-edge state, so a
  // LOAD arriving together with MODE 0->1 is still honoured from MANUAL, and
  // a scan step due on the edge that leaves SCAN still happens.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      o_q     <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      state  <= bus.MODE ? SCAN : MANUAL;

      if (state != IDLE) begin
        o_q     <= sel_data;
        valid_q <= 1'b1;
      end

      case (state)
        MANUAL: begin
          if (bus.LOAD) begin
            if (bad_sel) begin
              err_q <= 1'b1;
            end else begin
              sel_q <= bus.S;
            end
          end
        end
        SCAN: begin
          if (tc) begin
            sel_q  <= sel_step;
            wrap_q <= sel_at_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.O       = o_q;
  assign bus.SEL     = sel_q;
  assign bus.O_valid = valid_q;
  assign bus.WRAP    = wrap_q;
  assign bus.S_err   = err_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer. Three instances share clock and
// reset: u4 (N=4, DWELL=4), u3 (N=3, DWELL=2) and u1 (N=3, DWELL=1).
// Inputs change 1 time unit after a rising edge; outputs are checked at the
// same point, so each check sees the state produced by the preceding edge.
module tb_mux_scan_sequencer;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  int scan_sel  [7] = '{0, 0, 1, 1, 2, 2, 0};
  int scan_wrap [7] = '{0, 0, 0, 0, 0, 0, 1};

  mux_scan_sequencer_if #(.N(4), .W(8)) b4 ();
  mux_scan_sequencer_if #(.N(3), .W(8)) b3 ();
  mux_scan_sequencer_if #(.N(3), .W(8)) b1 ();

  mux_scan_sequencer #(.N(4), .W(8), .DWELL(4)) u4 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (b4.slave)
  );

  mux_scan_sequencer #(.N(3), .W(8), .DWELL(2)) u3 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (b3.slave)
  );

  mux_scan_sequencer #(.N(3), .W(8), .DWELL(1)) u1 (
    .CLK   (clk),
    .RESET (rst),
    .bus   (b1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst     = 1'b1;
    b4.I    = {8'h44, 8'h33, 8'h22, 8'h11};
    b4.S    = '0;
    b4.LOAD = 1'b0;
    b4.MODE = 1'b0;
    b3.I    = {8'hC3, 8'hB2, 8'hA1};
    b3.S    = '0;
    b3.LOAD = 1'b0;
    b3.MODE = 1'b0;
    b1.I    = {8'h03, 8'h02, 8'h01};
    b1.S    = '0;
    b1.LOAD = 1'b0;
    b1.MODE = 1'b0;

    // Reset / startup
    repeat (3) tick();
    check("rst_O",       b4.O,       8'h00);
    check("rst_SEL",     b4.SEL,     2'd0);
    check("rst_O_valid", b4.O_valid, 1'b0);
    check("rst_WRAP",    b4.WRAP,    1'b0);
    check("rst_S_err",   b4.S_err,   1'b0);
    rst = 1'b0;
    tick();
    check("idle_exit_O_valid", b4.O_valid, 1'b0);
    check("idle_exit_O",       b4.O,       8'h00);
    tick();
    check("first_O_valid", b4.O_valid, 1'b1);
    check("first_O",       b4.O,       8'h11);

    // Manual load, N=4
    b4.S = 2'd2; b4.LOAD = 1'b1;
    tick();
    check("load2_SEL",     b4.SEL, 2'd2);
    check("load2_O_stale", b4.O,   8'h11);
    b4.LOAD = 1'b0;
    tick();
    check("load2_O", b4.O, 8'h33);
    b4.S = 2'd0; b4.LOAD = 1'b1;
    tick();
    check("load0_SEL",     b4.SEL, 2'd0);
    check("load0_O_stale", b4.O,   8'h33);
    b4.LOAD = 1'b0;
    tick();
    check("load0_O", b4.O, 8'h11);
    b4.I[7:0] = 8'h5A;
    tick();
    check("data_latency_O", b4.O, 8'h5A);
    b4.I[7:0] = 8'h11;

    // Bad select, N=3
    b3.S = 2'd1; b3.LOAD = 1'b1;
    tick();
    check("n3_load1_SEL",   b3.SEL,   2'd1);
    check("n3_load1_S_err", b3.S_err, 1'b0);
    b3.S = 2'd3;
    tick();
    check("bad_SEL_hold", b3.SEL,   2'd1);
    check("bad_S_err",    b3.S_err, 1'b1);
    b3.LOAD = 1'b0;
    tick();
    check("bad_S_err_single", b3.S_err, 1'b0);
    b3.LOAD = 1'b1;
    tick();
    check("bad_b2b_1", b3.S_err, 1'b1);
    tick();
    check("bad_b2b_2",     b3.S_err, 1'b1);
    check("bad_b2b_SEL",   b3.SEL,   2'd1);
    b3.LOAD = 1'b0;
    tick();
    check("bad_b2b_end", b3.S_err, 1'b0);

    // Scan wrap, N=3, DWELL=2 (LOAD with bad S held during scan is ignored)
    b3.S = 2'd0; b3.LOAD = 1'b1;
    tick();
    check("scan_pre_SEL", b3.SEL, 2'd0);
    b3.LOAD = 1'b0;
    b3.MODE = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("scan_SEL_%0d", i),  b3.SEL,  scan_sel[i]);
      check($sformatf("scan_WRAP_%0d", i), b3.WRAP, scan_wrap[i]);
      if (i > 0) check($sformatf("scan_S_err_%0d", i), b3.S_err, 1'b0);
      if (i == 0) begin
        b3.S = 2'd3; b3.LOAD = 1'b1;
      end
      if (i == 3) check("scan_O_ch1", b3.O, 8'hB2);
    end
    b3.LOAD = 1'b0;
    tick();
    check("scan_WRAP_single", b3.WRAP, 1'b0);
    check("scan_SEL_7",       b3.SEL,  2'd0);
    tick();
    check("scan_SEL_8", b3.SEL, 2'd1);

    // Mode switch mid-dwell: freeze at 1, then resume with a fresh dwell
    b3.MODE = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("freeze_SEL_%0d", i), b3.SEL, 2'd1);
    end
    check("freeze_O", b3.O, 8'hB2);
    b3.MODE = 1'b1;
    tick();
    check("resume_SEL_0", b3.SEL, 2'd1);
    tick();
    check("resume_SEL_1", b3.SEL, 2'd1);
    tick();
    check("resume_SEL_2", b3.SEL, 2'd2);
    check("resume_O_2",   b3.O,   8'hB2);
    tick();
    check("resume_O_3", b3.O, 8'hC3);

    // DWELL=1: SEL advances every cycle
    b1.MODE = 1'b1;
    tick();
    check("d1_SEL_0", b1.SEL, 2'd0);
    tick();
    check("d1_SEL_1", b1.SEL, 2'd1);
    tick();
    check("d1_SEL_2", b1.SEL,  2'd2);
    check("d1_O_2",   b1.O,    8'h02);
    tick();
    check("d1_SEL_3",  b1.SEL,  2'd0);
    check("d1_WRAP_3", b1.WRAP, 1'b1);
    tick();
    check("d1_SEL_4",  b1.SEL,  2'd1);
    check("d1_WRAP_4", b1.WRAP, 1'b0);

    // Reset mid-scan (u3, u1) and mid-load (u4 presenting a bad load)
    check("pre_rst_O_valid", b3.O_valid, 1'b1);
    b4.S = 2'd3; b4.LOAD = 1'b1;
    rst = 1'b1;
    b3.MODE = 1'b0;
    b1.MODE = 1'b0;
    tick();
    check("midrst_O",       b3.O,       8'h00);
    check("midrst_SEL",     b3.SEL,     2'd0);
    check("midrst_O_valid", b3.O_valid, 1'b0);
    check("midrst_WRAP",    b3.WRAP,    1'b0);
    check("midrst_S_err",   b3.S_err,   1'b0);
    check("midrst_d1_SEL",  b1.SEL,     2'd0);
    check("midrst_ld_SEL",  b4.SEL,     2'd0);
    check("midrst_ld_err",  b4.S_err,   1'b0);
    b4.LOAD = 1'b0; b4.S = 2'd0;
    rst = 1'b0;
    tick();

    // Simultaneous LOAD and MODE 0->1 from MANUAL: load wins, scan from 2
    b4.S = 2'd2; b4.LOAD = 1'b1; b4.MODE = 1'b1;
    tick();
    check("sim_SEL_0", b4.SEL, 2'd2);
    check("sim_O_0",   b4.O,   8'h11);
    b4.S = 2'd0;
    tick();
    check("sim_load_ignored", b4.SEL, 2'd2);
    check("sim_O_1",          b4.O,   8'h33);
    b4.LOAD = 1'b0;
    tick();
    tick();
    check("sim_SEL_3", b4.SEL, 2'd2);
    tick();
    check("sim_SEL_4", b4.SEL, 2'd3);
    check("sim_O_4",   b4.O,   8'h33);
    repeat (3) tick();
    check("sim_SEL_7",  b4.SEL,  2'd3);
    check("sim_WRAP_7", b4.WRAP, 1'b0);
    tick();
    check("sim_SEL_8",  b4.SEL,  2'd0);
    check("sim_WRAP_8", b4.WRAP, 1'b1);
    check("sim_O_8",    b4.O,    8'h44);
    tick();
    check("sim_WRAP_9", b4.WRAP, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
